sync_fifo_ring: RTL and testbench

Parametrised synchronous FIFO built on a circular buffer with independent read and write pointers, replacing shift-register storage. It provides valid/ready handshakes on both sides, first-word-fall-through output, an occupancy count, programmable almost-full and almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It sits between a producer and a consumer in a single clock domain.

---
 rtl/sync_fifo_ring_pkg.sv | 18 +
 rtl/sync_fifo_ring_if.sv | 43 ++++
 rtl/sync_fifo_ring_mem.sv | 27 ++
 rtl/sync_fifo_ring.sv | 117 +++++++++++
 tb/tb_sync_fifo_ring.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_ring_pkg.sv
// Shared sizing defaults and width helpers for the ring-buffer FIFO.
// Imported by the interface and the top level so both derive identical widths.
package sync_fifo_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 256;
    localparam int DEFAULT_DATA_WIDTH = 32;

    // Pointers index FIFO_DEPTH entries and wrap naturally.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can represent a completely full FIFO.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ring_if.sv
// Producer/consumer handshake, level thresholds and status flags of sync_fifo_ring.
// The slave modport is the FIFO's view; the master modport is the surrounding logic's view.
interface sync_fifo_ring_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = cnt_width(DEFAULT_FIFO_DEPTH)
);

    logic                  i_flush;
    logic                  i_valid_s;
    logic                  o_ready_s;
    logic [DATA_WIDTH-1:0] i_datain;
    logic                  o_valid_m;
    logic                  i_ready_m;
    logic [DATA_WIDTH-1:0] o_dataout;
    logic [CNT_WIDTH-1:0]  i_almostfull_lvl;
    logic [CNT_WIDTH-1:0]  i_almostempty_lvl;
    logic [CNT_WIDTH-1:0]  o_count;
    logic                  o_full;
    logic                  o_empty;
    logic                  o_almostfull;
    logic                  o_almostempty;
    logic                  o_overflow;
    logic                  o_underflow;

    modport slave (
        input  i_flush, i_valid_s, i_datain, i_ready_m,
               i_almostfull_lvl, i_almostempty_lvl,
        output o_ready_s, o_valid_m, o_dataout, o_count,
               o_full, o_empty, o_almostfull, o_almostempty,
               o_overflow, o_underflow
    );

    modport master (
        output i_flush, i_valid_s, i_datain, i_ready_m,
               i_almostfull_lvl, i_almostempty_lvl,
        input  o_ready_s, o_valid_m, o_dataout, o_count,
               o_full, o_empty, o_almostfull, o_almostempty,
               o_overflow, o_underflow
    );

endinterface

// File: rtl/sync_fifo_ring_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Kept in its own module so it can be replaced by a vendor RAM primitive.
module sync_fifo_ring_mem #(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; the control logic never exposes stale entries.
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ring.sv
// Circular-buffer FIFO with first-word-fall-through output, occupancy count,
// programmable almost thresholds, synchronous flush and sticky error flags.
module sync_fifo_ring
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    sync_fifo_ring_if.slave bus
);

    localparam int PTR_WIDTH = ptr_width(FIFO_DEPTH);
    localparam int CNT_WIDTH = cnt_width(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);

    logic [PTR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_WIDTH-1:0] count_reg, count_next;
    logic                 overflow_reg, overflow_next;
    logic                 underflow_reg, underflow_next;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Status is decoded from registered occupancy only, so no input-to-output path exists.
    assign full  = (count_reg == DEPTH_CNT);
    assign empty = (count_reg == '0);

    assign push = bus.i_valid_s && !full;
    assign pop  = bus.i_ready_m && !empty;

    // A flush in the same cycle suppresses the write as well as the pointer moves.
    assign mem_we = push && !bus.i_flush;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        if (bus.i_flush) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            if (push && !pop) begin
                count_next = count_reg + CNT_ONE;
            end else if (pop && !push) begin
                count_next = count_reg - CNT_ONE;
            end
            if (bus.i_valid_s && full) begin
                overflow_next = 1'b1;
            end
            if (bus.i_ready_m && empty) begin
                underflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    sync_fifo_ring_mem #(
        .DEPTH      (FIFO_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .i_clk (i_clk),
        .we    (mem_we),
        .waddr (wr_ptr_reg),
        .wdata (bus.i_datain),
        .raddr (rd_ptr_reg),
        .rdata (mem_rdata)
    );

    assign bus.o_dataout     = mem_rdata;
    assign bus.o_count       = count_reg;
    assign bus.o_full        = full;
    assign bus.o_empty       = empty;
    assign bus.o_ready_s     = !full;
    assign bus.o_valid_m     = !empty;
    assign bus.o_almostfull  = (count_reg >= bus.i_almostfull_lvl);
    assign bus.o_almostempty = (count_reg <= bus.i_almostempty_lvl);
    assign bus.o_overflow    = overflow_reg;
    assign bus.o_underflow   = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_ring.sv
// Directed bench for sync_fifo_ring (depth 4, 8-bit data) with a queue-based
// reference model checked every falling edge plus hand-computed literal checks.
module tb_sync_fifo_ring;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int CW    = 3;

    logic i_clk;
    logic i_rst_n;

    sync_fifo_ring_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    sync_fifo_ring #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: contents as a queue, errors as plain sticky bits.
    logic [DW-1:0] m_q[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (bus.i_flush) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            automatic bit was_full  = (m_q.size() == DEPTH);
            automatic bit was_empty = (m_q.size() == 0);
            if (bus.i_valid_s && was_full)  m_ovf = 1'b1;
            if (bus.i_ready_m && was_empty) m_udf = 1'b1;
            if (bus.i_ready_m && !was_empty) void'(m_q.pop_front());
            if (bus.i_valid_s && !was_full)  m_q.push_back(bus.i_datain);
        end
    end

    always @(negedge i_clk) begin
        automatic int n = m_q.size();
        check("count",       32'(bus.o_count),       32'(n));
        check("empty",       32'(bus.o_empty),       32'(n == 0));
        check("full",        32'(bus.o_full),        32'(n == DEPTH));
        check("valid_m",     32'(bus.o_valid_m),     32'(n != 0));
        check("ready_s",     32'(bus.o_ready_s),     32'(n != DEPTH));
        check("almostfull",  32'(bus.o_almostfull),  32'(n >= int'(bus.i_almostfull_lvl)));
        check("almostempty", 32'(bus.o_almostempty), 32'(n <= int'(bus.i_almostempty_lvl)));
        check("overflow",    32'(bus.o_overflow),    32'(m_ovf));
        check("underflow",   32'(bus.o_underflow),   32'(m_udf));
        if (n != 0) check("dataout", 32'(bus.o_dataout), 32'(m_q[0]));
    end

    // Apply one cycle of inputs; returns 1 time unit after the following falling edge.
    task automatic cyc(input logic f, input logic v, input logic [DW-1:0] d, input logic r);
        bus.i_flush   = f;
        bus.i_valid_s = v;
        bus.i_datain  = d;
        bus.i_ready_m = r;
        @(posedge i_clk);
        @(negedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n               = 1'b0;
        bus.i_flush           = 1'b0;
        bus.i_valid_s         = 1'b0;
        bus.i_datain          = '0;
        bus.i_ready_m         = 1'b0;
        bus.i_almostfull_lvl  = 3'd0;
        bus.i_almostempty_lvl = 3'd1;

        #2;
        check("rst count",       32'(bus.o_count),       32'd0);
        check("rst empty",       32'(bus.o_empty),       32'd1);
        check("rst ready_s",     32'(bus.o_ready_s),     32'd1);
        check("rst valid_m",     32'(bus.o_valid_m),     32'd0);
        check("rst almostfull0", 32'(bus.o_almostfull),  32'd1);
        check("rst almostempty", 32'(bus.o_almostempty), 32'd1);
        bus.i_almostfull_lvl = 3'd3;
        #1;
        check("rst almostfull3", 32'(bus.o_almostfull),  32'd0);
        #9 i_rst_n = 1'b1;
        @(negedge i_clk);
        #1;

        // Fill: count 1..4, threshold crossings, then overflow.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 8'hA1 + 8'(i), 1'b0);
            check("fill count",       32'(bus.o_count),       32'(i + 1));
            check("fill almostfull",  32'(bus.o_almostfull),  32'(i >= 2));
            check("fill almostempty", 32'(bus.o_almostempty), 32'(i == 0));
        end
        check("full flag",    32'(bus.o_full),    32'd1);
        check("full ready_s", 32'(bus.o_ready_s), 32'd0);
        cyc(1'b0, 1'b1, 8'hA5, 1'b0);
        check("ovf set",   32'(bus.o_overflow), 32'd1);
        check("ovf count", 32'(bus.o_count),    32'd4);

        // Drain in order, then underflow.
        for (int i = 0; i < 4; i++) begin
            check("drain data", 32'(bus.o_dataout), 32'(8'hA1 + 8'(i)));
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            check("drain count", 32'(bus.o_count), 32'(3 - i));
        end
        check("drain empty", 32'(bus.o_empty), 32'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check("udf set", 32'(bus.o_underflow), 32'd1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        check("flush ovf", 32'(bus.o_overflow),  32'd0);
        check("flush udf", 32'(bus.o_underflow), 32'd0);

        // Steady-state streaming at count 2; pointers wrap several times.
        cyc(1'b0, 1'b1, 8'h10, 1'b0);
        cyc(1'b0, 1'b1, 8'h11, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("stream data", 32'(bus.o_dataout), 32'(8'h10 + 8'(i)));
            cyc(1'b0, 1'b1, 8'h12 + 8'(i), 1'b1);
            check("stream count", 32'(bus.o_count), 32'd2);
        end

        // Flush beats a simultaneous push and pop.
        cyc(1'b0, 1'b1, 8'h30, 1'b0);
        check("pre-flush count", 32'(bus.o_count), 32'd3);
        cyc(1'b1, 1'b1, 8'hEE, 1'b1);
        check("flush count", 32'(bus.o_count), 32'd0);
        check("flush empty", 32'(bus.o_empty), 32'd1);
        cyc(1'b0, 1'b1, 8'h55, 1'b0);
        check("post-flush data", 32'(bus.o_dataout), 32'h55);

        // Asynchronous reset in the middle of a burst.
        cyc(1'b0, 1'b1, 8'h56, 1'b0);
        bus.i_datain = 8'h57;
        i_rst_n = 1'b0;
        #1;
        check("arst count",   32'(bus.o_count),     32'd0);
        check("arst empty",   32'(bus.o_empty),     32'd1);
        check("arst valid_m", 32'(bus.o_valid_m),   32'd0);
        check("arst ready_s", 32'(bus.o_ready_s),   32'd1);
        check("arst ovf",     32'(bus.o_overflow),  32'd0);
        #1 i_rst_n = 1'b1;
        cyc(1'b0, 1'b1, 8'h58, 1'b0);
        check("arst refill data", 32'(bus.o_dataout), 32'h58);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
